// File: rtl/sram_ctrl.sv
// sram_ctrl: host valid/ready front end driving the single-port SRAM macro with its two-edge access.
// Latency: read data / write-done pulse two cycles after accept; one access per three cycles back-to-back.
// Backpressure: req_ready only in IDLE/RECOVER; responses are unbuffered pulses. Macro SRAM_CTRL_STATS_EN adds read/write counters.
module sram_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  wr_done,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_re_n,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [DATA_WIDTH-1:0] sram_wdata,
    input  logic [DATA_WIDTH-1:0] sram_rdata,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RECOVER} state_t;

    state_t                state_q, state_d;
    logic                  wr_q, wr_d;
    logic                  ce_n_q, ce_n_d;
    logic                  we_n_q, we_n_d;
    logic                  re_n_q, re_n_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  wr_done_q, wr_done_d;
    logic                  can_accept;

    // Ready is a pure decode of the registered state, forced low while reset is held.
    assign can_accept = (state_q == IDLE) || (state_q == RECOVER);
    assign req_ready  = can_accept && !reset;

    // Next-state and next-output decode; every macro-facing signal is computed here and then registered.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        ce_n_d      = 1'b1;
        we_n_d      = 1'b1;
        re_n_d      = 1'b1;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rsp_valid_d = 1'b0;
        wr_done_d   = 1'b0;
        case (state_q)
            IDLE, RECOVER: begin
                if (req_valid) begin
                    // Strobes go low at the accept edge so SETUP already presents them to the macro.
                    state_d = SETUP;
                    wr_d    = req_write;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    ce_n_d  = 1'b0;
                    we_n_d  = !req_write;
                    re_n_d  = req_write;
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                // Hold strobes for the second edge the macro needs.
                state_d = ACCESS;
                ce_n_d  = 1'b0;
                we_n_d  = !wr_q;
                re_n_d  = wr_q;
            end
            ACCESS: begin
                // Closing edge: read data is captured, the macro commits a write; strobes release.
                state_d = RECOVER;
                if (wr_q) begin
                    wr_done_d = 1'b1;
                end else begin
                    rdata_d     = sram_rdata;
                    rsp_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset releases the strobes immediately, abandoning any access.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            wr_q        <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            re_n_q      <= 1'b1;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            wr_done_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            ce_n_q      <= ce_n_d;
            we_n_q      <= we_n_d;
            re_n_q      <= re_n_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            wr_done_q   <= wr_done_d;
        end
    end

    assign sram_ce_n  = ce_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_re_n  = re_n_q;
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_valid  = rsp_valid_q;
    assign wr_done    = wr_done_q;

`ifdef SRAM_CTRL_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    // Saturating completion counters, bumped on the response pulses.
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (rsp_valid_q && (rd_count_q != 16'hFFFF)) rd_count_d = rd_count_q + 16'd1;
        if (wr_done_q && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
